// File: rtl/control_sequencer.sv
// Hard-wired fetch/decode/execute sequencer for the single-bus CPU datapath.
// Control strobes are Moore-decoded from the state register and the IR contents.
module control_sequencer #(
  parameter int unsigned OPW  = 5,
  parameter int unsigned CNTW = 16
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            run,
  input  logic            stop,
  input  logic [31:0]     ir,
  output logic            PCout,
  output logic            MDRout,
  output logic            Zhighout,
  output logic            Zlowout,
  output logic [15:0]     Rout,
  output logic [15:0]     Rin,
  output logic            MARin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            HIin,
  output logic            LOin,
  output logic            ZHighIn,
  output logic            ZLowIn,
  output logic            IncPC,
  output logic            Read,
  output logic [OPW-1:0]  opcode,
  output logic            halted,
  output logic            illegal,
  output logic [CNTW-1:0] instr_count
);

  localparam int unsigned RW = 16;
  localparam logic [OPW-1:0] OP_ALU_MAX = OPW'(12);
  localparam logic [OPW-1:0] OP_MUL     = OPW'(15);
  localparam logic [OPW-1:0] OP_DIV     = OPW'(16);
  localparam logic [OPW-1:0] OP_NOP     = OPW'(26);
  localparam logic [OPW-1:0] OP_HALT    = OPW'(27);

  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;

  state_t          state;
  logic            need_edge;
  logic [OPW-1:0]  op;
  logic            is_alu, is_muldiv, is_halt, is_short, is_illegal, retire;
  logic [RW-1:0]   sel_ra, sel_rb, sel_rc;
  logic            unused_ir;

  assign op         = ir[31 -: OPW];
  assign opcode     = op;
  assign is_alu     = (op <= OP_ALU_MAX);
  assign is_muldiv  = (op == OP_MUL) || (op == OP_DIV);
  assign is_halt    = (op == OP_HALT);
  assign is_short   = !(is_alu || is_muldiv);
  assign is_illegal = is_short && !is_halt && (op != OP_NOP);
  assign sel_ra     = RW'(1) << ir[26:23];
  assign sel_rb     = RW'(1) << ir[22:19];
  assign sel_rc     = RW'(1) << ir[18:15];
  assign unused_ir  = ^ir[14:0];

  assign retire = ((state == T3) && is_short) ||
                  ((state == T5) && !is_muldiv) ||
                  (state == T6);

  // need_edge blocks a restart until run has been seen low (after reset or halt)
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state       <= IDLE;
      need_edge   <= 1'b1;
      instr_count <= '0;
    end else begin
      if (!run) need_edge <= 1'b0;
      if (retire) begin
        instr_count <= instr_count + CNTW'(1);
        if (is_halt) begin
          state     <= HALT;
          need_edge <= run;
        end else if (stop) begin
          state <= IDLE;
        end else begin
          state <= T0;
        end
      end else begin
        case (state)
          IDLE, HALT: if (run && !need_edge) state <= T0;
          T0:         state <= T1;
          T1:         state <= T2;
          T2:         state <= T3;
          T3:         state <= T4;
          T4:         state <= T5;
          T5:         state <= T6;
          default:    state <= IDLE;
        endcase
      end
    end
  end

  // Per-state strobe decode; everything not named for a state stays low
  always_comb begin
    PCout    = 1'b0;
    MDRout   = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    Rout     = '0;
    Rin      = '0;
    MARin    = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    ZHighIn  = 1'b0;
    ZLowIn   = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    illegal  = 1'b0;
    halted   = (state == IDLE) || (state == HALT);
    case (state)
      T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
      end
      T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        if (is_short) begin
          illegal = is_illegal;
        end else begin
          Rout = sel_rb;
          Yin  = 1'b1;
        end
      end
      T4: begin
        Rout    = sel_rc;
        ZLowIn  = 1'b1;
        ZHighIn = is_muldiv;
      end
      T5: begin
        Zlowout = 1'b1;
        if (is_muldiv) LOin = 1'b1;
        else           Rin  = sel_ra;
      end
      T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle strobe checks against hand-computed values.
module tb_control_sequencer;

  localparam int unsigned OPW  = 5;
  localparam int unsigned CNTW = 8;

  localparam logic [16:0] F_PCOUT  = 17'h00001;
  localparam logic [16:0] F_MDROUT = 17'h00002;
  localparam logic [16:0] F_ZHOUT  = 17'h00004;
  localparam logic [16:0] F_ZLOUT  = 17'h00008;
  localparam logic [16:0] F_MARIN  = 17'h00010;
  localparam logic [16:0] F_MDRIN  = 17'h00040;
  localparam logic [16:0] F_IRIN   = 17'h00080;
  localparam logic [16:0] F_YIN    = 17'h00100;
  localparam logic [16:0] F_HIIN   = 17'h00200;
  localparam logic [16:0] F_LOIN   = 17'h00400;
  localparam logic [16:0] F_ZHIN   = 17'h00800;
  localparam logic [16:0] F_ZLIN   = 17'h01000;
  localparam logic [16:0] F_INCPC  = 17'h02000;
  localparam logic [16:0] F_READ   = 17'h04000;
  localparam logic [16:0] F_ILL    = 17'h08000;
  localparam logic [16:0] F_HALTED = 17'h10000;
  localparam logic [16:0] F_T0     = F_PCOUT | F_MARIN | F_INCPC;
  localparam logic [16:0] F_T1     = F_READ | F_MDRIN;
  localparam logic [16:0] F_T2     = F_MDROUT | F_IRIN;

  logic            clock;
  logic            clear, run, stop;
  logic [31:0]     ir;
  logic            PCout, MDRout, Zhighout, Zlowout;
  logic [15:0]     Rout, Rin;
  logic            MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn;
  logic            IncPC, Read, halted, illegal;
  logic [OPW-1:0]  opcode;
  logic [CNTW-1:0] instr_count;
  logic [16:0]     flags;

  int n_checks = 0;
  int n_pass   = 0;

  control_sequencer #(.OPW(OPW), .CNTW(CNTW)) dut (
    .clock(clock), .clear(clear), .run(run), .stop(stop), .ir(ir),
    .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .Rout(Rout), .Rin(Rin), .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn),
    .ZLowIn(ZLowIn), .IncPC(IncPC), .Read(Read), .opcode(opcode),
    .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  assign flags = {halted, illegal, Read, IncPC, ZLowIn, ZHighIn, LOin, HIin, Yin,
                  IRin, MDRin, PCin, MARin, Zlowout, Zhighout, MDRout, PCout};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic chk_ctl(input string tag, input logic [16:0] f, input logic [15:0] ro,
                         input logic [15:0] ri);
    check({tag, "_flags"}, 32'(flags), 32'(f));
    check({tag, "_rout"},  32'(Rout),  32'(ro));
    check({tag, "_rin"},   32'(Rin),   32'(ri));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input string tag);
    step(); chk_ctl({tag, "_t1"}, F_T1, 16'h0, 16'h0);
    step(); chk_ctl({tag, "_t2"}, F_T2, 16'h0, 16'h0);
  endtask

  initial begin
    clear = 1'b0; run = 1'b1; stop = 1'b0; ir = 32'h0;
    repeat (2) step();
    chk_ctl("reset", F_HALTED, 16'h0, 16'h0);
    check("reset_cnt", 32'(instr_count), 32'd0);

    // run held high through reset must not start
    clear = 1'b1;
    repeat (3) step();
    chk_ctl("run_held_after_reset", F_HALTED, 16'h0, 16'h0);
    run = 1'b0; step();
    chk_ctl("idle_run_low", F_HALTED, 16'h0, 16'h0);
    run = 1'b1; step();
    chk_ctl("first_t0", F_T0, 16'h0, 16'h0);

    // ALU: op 0, Ra=2, Rb=3, Rc=1
    ir = 32'h01188000;
    fetch("alu");
    step(); chk_ctl("alu_t3", F_YIN, 16'h0008, 16'h0);
    check("alu_opcode", 32'(opcode), 32'd0);
    step(); chk_ctl("alu_t4", F_ZLIN, 16'h0002, 16'h0);
    step(); chk_ctl("alu_t5", F_ZLOUT, 16'h0, 16'h0004);
    check("alu_cnt_before", 32'(instr_count), 32'd0);
    step(); chk_ctl("alu_next_t0", F_T0, 16'h0, 16'h0);
    check("alu_cnt_after", 32'(instr_count), 32'd1);

    // mul: op 15, Ra=3, Rb=4, Rc=0
    ir = 32'h79A00000;
    fetch("mul");
    check("mul_opcode", 32'(opcode), 32'd15);
    step(); chk_ctl("mul_t3", F_YIN, 16'h0010, 16'h0);
    step(); chk_ctl("mul_t4", F_ZHIN | F_ZLIN, 16'h0001, 16'h0);
    step(); chk_ctl("mul_t5", F_ZLOUT | F_LOIN, 16'h0, 16'h0);
    step(); chk_ctl("mul_t6", F_ZHOUT | F_HIIN, 16'h0, 16'h0);
    step(); chk_ctl("mul_next_t0", F_T0, 16'h0, 16'h0);
    check("mul_cnt", 32'(instr_count), 32'd2);

    // illegal opcode 31
    ir = 32'hF8000000;
    fetch("ill");
    step(); chk_ctl("ill_t3", F_ILL, 16'h0, 16'h0);
    step(); chk_ctl("ill_next_t0", F_T0, 16'h0, 16'h0);
    check("ill_cnt", 32'(instr_count), 32'd3);

    // nop with stop raised mid-instruction: ignored until retire, then IDLE
    ir = 32'hD0000000; stop = 1'b1;
    fetch("nop_stop");
    step(); chk_ctl("nop_t3", 17'h0, 16'h0, 16'h0);
    step(); chk_ctl("stop_idle", F_HALTED, 16'h0, 16'h0);
    check("stop_cnt", 32'(instr_count), 32'd4);
    stop = 1'b0;
    step(); chk_ctl("idle_restart_t0", F_T0, 16'h0, 16'h0);

    // halt together with stop: halt wins, needs a fresh run edge
    ir = 32'hD8000000; stop = 1'b1;
    fetch("halt");
    step(); chk_ctl("halt_t3", 17'h0, 16'h0, 16'h0);
    step(); chk_ctl("halt_state", F_HALTED, 16'h0, 16'h0);
    check("halt_cnt", 32'(instr_count), 32'd5);
    stop = 1'b0;
    repeat (3) step();
    chk_ctl("halt_run_held", F_HALTED, 16'h0, 16'h0);
    run = 1'b0; step();
    chk_ctl("halt_run_low", F_HALTED, 16'h0, 16'h0);
    run = 1'b1; step();
    chk_ctl("halt_restart_t0", F_T0, 16'h0, 16'h0);

    // asynchronous clear during T4
    ir = 32'h01188000;
    fetch("abort");
    step(); step();
    chk_ctl("abort_t4", F_ZLIN, 16'h0002, 16'h0);
    #2 clear = 1'b0;
    #1;
    chk_ctl("async_clear", F_HALTED, 16'h0, 16'h0);
    check("async_clear_cnt", 32'(instr_count), 32'd0);
    step();
    clear = 1'b1;
    repeat (2) step();
    chk_ctl("post_clear_idle", F_HALTED, 16'h0, 16'h0);

    // counter wrap: 2^CNTW - 1 back-to-back nops, then one more
    run = 1'b0; step();
    run = 1'b1; step();
    chk_ctl("wrap_start_t0", F_T0, 16'h0, 16'h0);
    ir = 32'hD0000000;
    repeat (255 * 4) step();
    chk_ctl("wrap_full_t0", F_T0, 16'h0, 16'h0);
    check("wrap_cnt_full", 32'(instr_count), 32'd255);
    repeat (4) step();
    check("wrap_cnt_zero", 32'(instr_count), 32'd0);
    chk_ctl("wrap_next_t0", F_T0, 16'h0, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hard-wired control unit that drives the CPU datapath through the fetch/decode/execute sequence. Each step issues one cycle of bus-driver selects (`*out`), register load enables (`*in`), PC increment, memory read and ALU opcode. It decodes the instruction held in IR into register-file selects and completes one register-to-register ALU, multiply/divide, nop or halt instruction per pass. It sits beside the datapath and replaces the testbench-driven control inputs.

## Interface
Parameters:
- `OPW`, 5, opcode width (IR[31:27])
- `CNTW`, 16, width of retired-instruction counter

Ports:
- `clock`  in  1  system clock; all state updates on rising edge
- `clear`  in  1  asynchronous, active-low reset
- `run`  in  1  level; start/resume request
- `stop`  in  1  level; halt request, honoured only at instruction boundary
- `ir`  in  32  IR contents: [31:27] opcode, [26:23] Ra (dest), [22:19] Rb, [18:15] Rc
- `PCout, MDRout, Zhighout, Zlowout`  out  1 each  bus driver selects
- `Rout`  out  16  one-hot register-file bus driver select (bit n = Rn)
- `Rin`  out  16  one-hot register-file load enable
- `MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn`  out  1 each  load enables (`PCin` is always 0 in this block)
- `IncPC, Read`  out  1 each  PC increment, memory read strobe into MDR
- `opcode`  out  5  ALU operation, equal to `ir[31:27]` at all times
- `halted`  out  1  high in IDLE and HALT
- `illegal`  out  1  one-cycle pulse on an undefined opcode
- `instr_count`  out  CNTW  retired instructions

## Operation
- Opcodes:
  - 0–12: ALU reg-reg; Ra ← Rb op Rc.
  - 15: mul. 16: div. Both produce {HI,LO} ← Rb op Rc.
  - 26: nop. 27: halt.
  - All others are illegal and execute as nop with `illegal` pulsed in T3.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT.
- Control outputs are Moore-decoded from the registered state plus `ir`. Every control output not listed for a state is 0. `Rout`/`Rin` are one-hot from the 4-bit field or all-zero.
- IDLE: all controls 0. Next state is T0 if `run`=1, else IDLE.
- T0: PCout, MARin, IncPC. Next state T1.
- T1: Read, MDRin. Next state T2.
- T2: MDRout, IRin. Next state T3.
- T3:
  - nop/halt/illegal: no controls; the instruction retires.
  - Otherwise: Rout[Rb], Yin. Next state T4.
- T4: Rout[Rc], ZLowIn, plus ZHighIn for mul/div. Next state T5.
- T5:
  - ALU: Zlowout, Rin[Ra]; the instruction retires.
  - mul/div: Zlowout, LOin. Next state T6.
- T6: Zhighout, HIin; the instruction retires.
- Retire (end of T3 for nop/halt/illegal, T5 for ALU, T6 for mul/div):
  - `instr_count` increments, wrapping modulo 2^CNTW.
  - halt opcode → HALT.
  - Else `stop`=1 → IDLE.
  - Else → T0.
- HALT: behaves like IDLE, but requires `run` to be deasserted at least one cycle and then reasserted before going to T0. This is a rising-edge detect of `run` registered inside the block.
- Simultaneous halt opcode and `stop`: halt wins.
- `stop` mid-instruction is ignored until retire.
- `ir` is sampled combinationally in T3–T6. IR must be stable from the cycle after T2 until retire.

## Timing
- Reset (`clear`=0), asynchronous:
  - state = IDLE, all control outputs 0, `halted`=1, `illegal`=0, `instr_count`=0, `run` edge register = 1.
  - Holding `run` high through reset does not start execution until `run` drops and rises again.
- Instruction latency from the T0 cycle to the retire cycle inclusive:
  - nop/halt/illegal: 4 cycles.
  - ALU: 6 cycles.
  - mul/div: 7 cycles.
  - Back-to-back instructions have no gap cycle.
- Start-up: the first T0 occurs in the cycle after `run` is sampled high in IDLE.
- Reset mid-instruction: the sequencer aborts immediately with all enables low. No partial register write is issued after `clear` falls.
- `halted` is registered, i.e. decoded from the state register. It rises in the cycle after the halt opcode retires.

## Test plan
- Reset with `run`=1 held, then `run` 1→0→1 → first T0 cycle follows the rising edge; in T0 the outputs are PCout=MARin=IncPC=1 and all others 0.
- ALU instruction `ir`=0x01188000 (op 0, Ra=2, Rb=3, Rc=1) → exactly 6 cycles: T3 Rout=0x0008 with Yin; T4 Rout=0x0002 with ZLowIn; T5 Zlowout with Rin=0x0004; `instr_count` 0→1.
- mul `ir`=0x79A00000 (op 15, Rb=4, Rc=0) → T4 asserts ZHighIn and ZLowIn; T5 Zlowout with LOin; T6 Zhighout with HIin; retire after 7 cycles; `Rin` stays 0 throughout.
- Halt opcode 27 with `stop`=1 in the same retire cycle → HALT state, `halted`=1. `run` held high gives no restart; `run` dropped then raised → T0.
- Opcode 31 → `illegal`=1 for one cycle in T3, no register enables, `instr_count` increments, next state T0.
- Preload `instr_count` by running 65535 nops, then one more → `instr_count` wraps to 0. Separately, `clear` low during T4 → all outputs 0 asynchronously and state is IDLE.
